// File: rtl/rv_decode_queue.sv
// RV32I registered decode stage: decodes each accepted instruction and queues
// pc/inst/control in a DEPTH-entry FIFO whose head feeds the execute stage.
module rv_decode_queue #(
  parameter int DEPTH    = 2,
  parameter int EN_M     = 0,
  parameter int EN_ZICSR = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_inst,
  output logic [31:0]      out_ctrl,
  output logic [1:0]       out_exc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_SYS = 7'b1110011;
  localparam logic [1:0] EXC_IDLE = 2'd0, EXC_ECALL = 2'd1, EXC_EBREAK = 2'd2, EXC_MRET = 2'd3;
  localparam logic [2:0] SEXT_I = 3'd1, SEXT_S = 3'd2, SEXT_B = 3'd3, SEXT_U = 3'd4, SEXT_J = 3'd5;
  localparam logic [1:0] NPC_PC4 = 2'd0, NPC_BR = 2'd1, NPC_JAL = 2'd2, NPC_JALR = 2'd3;
  localparam logic [2:0] WB_ALU = 3'd0, WB_MEM = 3'd1, WB_PC4 = 3'd2, WB_EXT = 3'd3, WB_CSR = 3'd4;

  // ADD=0 SUB=1 SLL=2 SLT=3 SLTU=4 XOR=5 SRL=6 SRA=7 OR=8 AND=9
  function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_from_f3 = alt ? 5'd1 : 5'd0;
      3'b001:  alu_from_f3 = 5'd2;
      3'b010:  alu_from_f3 = 5'd3;
      3'b011:  alu_from_f3 = 5'd4;
      3'b100:  alu_from_f3 = 5'd5;
      3'b101:  alu_from_f3 = alt ? 5'd7 : 5'd6;
      3'b110:  alu_from_f3 = 5'd8;
      3'b111:  alu_from_f3 = 5'd9;
      default: alu_from_f3 = 5'd0;
    endcase
  endfunction

  logic [6:0]  opc_s, f7_s;
  logic [2:0]  f3_s;
  logic [11:0] f12_s;
  logic [4:0]  alu_op_s;
  logic [2:0]  alu_f_op_s, sext_op_s, mem_ext_op_s, rf_wsel_s;
  logic [1:0]  npc_op_s, ram_w_op_s, csr_wdata_op_s, exc_s;
  logic        ram_we_s, alu_a_sel_s, alu_b_sel_s, rd1_en_s, rd2_en_s, rf_we_s;
  logic        is_load_s, csr_we_s, csr_wdata_sel_s, ill_s;
  logic [31:0] ctrl_s;

  assign opc_s = in_inst[6:0];
  assign f3_s  = in_inst[14:12];
  assign f7_s  = in_inst[31:25];
  assign f12_s = in_inst[31:20];

  // instruction decode
  always_comb begin
    alu_op_s = 5'd0; alu_f_op_s = 3'd0; sext_op_s = 3'd0; npc_op_s = NPC_PC4;
    ram_we_s = 1'b0; ram_w_op_s = 2'd0; mem_ext_op_s = 3'd0; alu_a_sel_s = 1'b0;
    alu_b_sel_s = 1'b0; rd1_en_s = 1'b0; rd2_en_s = 1'b0; rf_we_s = 1'b0;
    rf_wsel_s = WB_ALU; is_load_s = 1'b0; csr_we_s = 1'b0; csr_wdata_sel_s = 1'b0;
    csr_wdata_op_s = 2'd0; exc_s = EXC_IDLE; ill_s = 1'b0;
    case (opc_s)
      OP_R: begin
        rd1_en_s = 1'b1; rd2_en_s = 1'b1; rf_we_s = 1'b1;
        if (f7_s == 7'b0000000) begin
          alu_op_s = alu_from_f3(f3_s, 1'b0);
        end else if (f7_s == 7'b0100000 && (f3_s == 3'b000 || f3_s == 3'b101)) begin
          alu_op_s = alu_from_f3(f3_s, 1'b1);
        end else if (f7_s == 7'b0000001 && EN_M != 0) begin
          alu_op_s = {2'b10, f3_s};
        end else begin
          ill_s = 1'b1;
        end
      end
      OP_I: begin
        rd1_en_s = 1'b1; rf_we_s = 1'b1; alu_b_sel_s = 1'b1; sext_op_s = SEXT_I;
        alu_op_s = alu_from_f3(f3_s, f7_s[5]);
        if (f3_s == 3'b001) begin
          ill_s = (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          ill_s = (f7_s != 7'b0000000) && (f7_s != 7'b0100000);
        end else begin
          alu_op_s = alu_from_f3(f3_s, 1'b0);
        end
      end
      OP_LD: begin
        rd1_en_s = 1'b1; rf_we_s = 1'b1; alu_b_sel_s = 1'b1; sext_op_s = SEXT_I;
        rf_wsel_s = WB_MEM; is_load_s = 1'b1; mem_ext_op_s = f3_s;
        ill_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
      end
      OP_ST: begin
        rd1_en_s = 1'b1; rd2_en_s = 1'b1; alu_b_sel_s = 1'b1; sext_op_s = SEXT_S;
        ram_we_s = 1'b1; ram_w_op_s = f3_s[1:0];
        ill_s = f3_s[2] || (f3_s[1:0] == 2'b11);
      end
      OP_BR: begin
        rd1_en_s = 1'b1; rd2_en_s = 1'b1; sext_op_s = SEXT_B; npc_op_s = NPC_BR; alu_op_s = 5'd1;
        case (f3_s)
          3'b000:  alu_f_op_s = 3'd1;
          3'b001:  alu_f_op_s = 3'd2;
          3'b100:  alu_f_op_s = 3'd3;
          3'b101:  alu_f_op_s = 3'd4;
          3'b110:  alu_f_op_s = 3'd5;
          3'b111:  alu_f_op_s = 3'd6;
          default: ill_s = 1'b1;
        endcase
      end
      OP_JAL: begin
        sext_op_s = SEXT_J; npc_op_s = NPC_JAL; rf_we_s = 1'b1; rf_wsel_s = WB_PC4;
      end
      OP_JALR: begin
        rd1_en_s = 1'b1; sext_op_s = SEXT_I; npc_op_s = NPC_JALR; rf_we_s = 1'b1;
        rf_wsel_s = WB_PC4; ill_s = (f3_s != 3'b000);
      end
      OP_LUI: begin
        sext_op_s = SEXT_U; rf_we_s = 1'b1; rf_wsel_s = WB_EXT;
      end
      OP_AUIPC: begin
        sext_op_s = SEXT_U; rf_we_s = 1'b1; alu_a_sel_s = 1'b1; alu_b_sel_s = 1'b1;
      end
      OP_SYS: begin
        if (f3_s == 3'b000) begin
          case (f12_s)
            12'h000: exc_s = EXC_ECALL;
            12'h001: exc_s = EXC_EBREAK;
            12'h302: exc_s = EXC_MRET;
            default: ill_s = 1'b1;
          endcase
        end else if (f3_s == 3'b100 || EN_ZICSR == 0) begin
          ill_s = 1'b1;
        end else begin
          // funct3[2] selects the zero-extended uimm instead of rs1
          csr_we_s = 1'b1; rf_we_s = 1'b1; rf_wsel_s = WB_CSR; rd1_en_s = !f3_s[2];
          csr_wdata_sel_s = f3_s[2]; csr_wdata_op_s = f3_s[1:0] - 2'd1;
        end
      end
      default: ill_s = 1'b1;
    endcase
  end

  // illegal words collapse to all-zero control, which encodes the safe default
  assign ctrl_s = ill_s ? 32'd0 :
                  {csr_wdata_op_s, csr_wdata_sel_s, csr_we_s, is_load_s, rf_wsel_s, rf_we_s,
                   rd2_en_s, rd1_en_s, alu_b_sel_s, alu_a_sel_s, mem_ext_op_s, ram_w_op_s,
                   ram_we_s, npc_op_s, sext_op_s, alu_f_op_s, alu_op_s};

  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      ctrl_q [DEPTH];
  logic [1:0]       exc_q [DEPTH];
  logic             ill_q [DEPTH];
  logic             push_s, pop_s;

  assign in_ready    = (count_q < FULL);
  assign out_valid   = (count_q != '0);
  assign push_s      = in_valid && in_ready && !flush;
  assign pop_s       = out_valid && out_ready;
  assign out_pc      = pc_q[rd_ptr_q];
  assign out_inst    = inst_q[rd_ptr_q];
  assign out_ctrl    = ctrl_q[rd_ptr_q];
  assign out_exc     = exc_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];
  assign illegal_cnt = cnt_q;

  // queue pointer, occupancy and counter next state
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_s && ill_s && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    if (flush) begin
      count_d = '0; wr_ptr_d = '0; rd_ptr_d = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + PW'(1);
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // state and entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= 32'd0; inst_q[i] <= 32'd0; ctrl_q[i] <= 32'd0;
        exc_q[i] <= EXC_IDLE; ill_q[i] <= 1'b0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_s) begin
        pc_q[wr_ptr_q]   <= in_pc;
        inst_q[wr_ptr_q] <= in_inst;
        ctrl_q[wr_ptr_q] <= ctrl_s;
        exc_q[wr_ptr_q]  <= exc_s;
        ill_q[wr_ptr_q]  <= ill_s;
      end
    end
  end
endmodule
